hop_chain_sequencer: RTL and testbench



---
 rtl/hop_seq_pkg.sv | 26 ++
 rtl/hop_rst_release.sv | 39 +++
 rtl/hop_chain_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_hop_chain_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hop_seq_pkg.sv
// Shared types and default sizing for the hop-chain run sequencer.
package hop_seq_pkg;

    localparam int NUM_RST_DEF = 16;
    localparam int LAT_W_DEF   = 6;
    localparam int TIMEOUT_DEF = 63;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        RELEASE,
        SETTLE,
        LAUNCH,
        WAIT,
        REPORT
    } hop_state_e;

    typedef struct packed {
        logic                 pass;
        logic [LAT_W_DEF-1:0] lat_a;
        logic [LAT_W_DEF-1:0] lat_b;
        logic                 err_timeout;
        logic                 err_early;
    } hop_result_t;

endpackage

// File: rtl/hop_rst_release.sv
// Staggered stage-reset release: loads all ones, then clears one more bit
// from the LSB upward on each shift.
module hop_rst_release
    import hop_seq_pkg::*;
#(
    parameter int NUM_RST = NUM_RST_DEF
) (
    input  logic               clock0,
    input  logic               rst0,
    input  logic               load_all,
    input  logic               shift_en,
    output logic [NUM_RST-1:0] stage_rst,
    output logic               last_released
);

    logic [NUM_RST-1:0] sr_q;
    logic [NUM_RST-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_all) begin
            sr_d = '1;
        end else if (shift_en) begin
            sr_d = {sr_q[NUM_RST-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock0) begin
        if (rst0) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign stage_rst     = sr_q;
    assign last_released = (sr_q == '0);

endmodule

// File: rtl/hop_chain_sequencer.sv
// Run controller for the dual hop chain: reset hold, staggered release,
// single launch, latency capture and pass/fail report.
//
//   state   | meaning
//   IDLE    | all stage resets held, waiting for go
//   ASSERT  | all stage resets held for RST_CYCLES
//   RELEASE | one stage reset released per cycle, LSB first
//   SETTLE  | quiet cycles; any chain output high flags err_early
//   LAUNCH  | start1/start2 pulse, wait counter at 0
//   WAIT    | counting; first high per chain latches its latency
//   REPORT  | done pulse, pass/err_timeout valid
module hop_chain_sequencer
    import hop_seq_pkg::*;
#(
    parameter int NUM_RST       = NUM_RST_DEF,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int EXP_LAT_A     = 9,
    parameter int EXP_LAT_B     = 9,
    parameter int TIMEOUT       = TIMEOUT_DEF,
    parameter int LAT_W         = LAT_W_DEF
) (
    input  logic               clock0,
    input  logic               rst0,
    input  logic               go,
    input  logic               chain_a_out,
    input  logic               chain_b_out,
    output logic [NUM_RST-1:0] stage_rst,
    output logic               start1,
    output logic               start2,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [LAT_W-1:0]   lat_a,
    output logic [LAT_W-1:0]   lat_b,
    output logic               err_timeout,
    output logic               err_early
);

    localparam int TMR_W = 8;

    hop_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_a_q, lat_a_d;
    logic [LAT_W-1:0] lat_b_q, lat_b_d;
    logic             seen_a_q, seen_a_d;
    logic             seen_b_q, seen_b_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_early_q, err_early_d;
    logic             load_all;
    logic             shift_en;
    logic             last_released;
    logic             chain_any;

    hop_rst_release #(
        .NUM_RST(NUM_RST)
    ) u_release (
        .clock0        (clock0),
        .rst0          (rst0),
        .load_all      (load_all),
        .shift_en      (shift_en),
        .stage_rst     (stage_rst),
        .last_released (last_released)
    );

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        cnt_d         = '0;
        lat_a_d       = lat_a_q;
        lat_b_d       = lat_b_q;
        seen_a_d      = seen_a_q;
        seen_b_d      = seen_b_q;
        pass_d        = pass_q;
        err_timeout_d = err_timeout_q;
        err_early_d   = err_early_q;
        load_all      = 1'b0;
        shift_en      = 1'b0;
        chain_any     = chain_a_out | chain_b_out;

        unique case (state_q)
            IDLE: begin
                load_all = 1'b1;
                if (go) begin
                    state_d       = ASSERT;
                    tmr_d         = TMR_W'(RST_CYCLES - 1);
                    lat_a_d       = '0;
                    lat_b_d       = '0;
                    seen_a_d      = 1'b0;
                    seen_b_d      = 1'b0;
                    pass_d        = 1'b0;
                    err_timeout_d = 1'b0;
                    err_early_d   = 1'b0;
                end
            end
            ASSERT: begin
                // Shift on the last hold cycle so bit 0 is already low in
                // the first RELEASE cycle.
                if (tmr_q == '0) begin
                    state_d  = RELEASE;
                    shift_en = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RELEASE: begin
                if (last_released) begin
                    state_d = SETTLE;
                    tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
                end else begin
                    shift_en = 1'b1;
                end
            end
            SETTLE: begin
                if (chain_any) begin
                    err_early_d = 1'b1;
                end
                if (tmr_q == '0) begin
                    state_d = LAUNCH;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            LAUNCH: begin
                if (chain_any) begin
                    err_early_d = 1'b1;
                end
                cnt_d   = cnt_q + LAT_W'(1);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = (cnt_q == LAT_W'(TIMEOUT)) ? cnt_q : cnt_q + LAT_W'(1);
                if (chain_a_out && !seen_a_q) begin
                    seen_a_d = 1'b1;
                    lat_a_d  = cnt_q;
                end
                if (chain_b_out && !seen_b_q) begin
                    seen_b_d = 1'b1;
                    lat_b_d  = cnt_q;
                end
                if ((seen_a_d && seen_b_d) || (cnt_q == LAT_W'(TIMEOUT))) begin
                    state_d       = REPORT;
                    err_timeout_d = !(seen_a_d && seen_b_d);
                    pass_d        = seen_a_d && seen_b_d && !err_early_q &&
                                    (lat_a_d == LAT_W'(EXP_LAT_A)) &&
                                    (lat_b_d == LAT_W'(EXP_LAT_B));
                end
            end
            REPORT: begin
                load_all = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                load_all = 1'b1;
                state_d  = IDLE;
            end
        endcase

        start_d = (state_d == LAUNCH);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == REPORT);
    end

    always_ff @(posedge clock0) begin
        if (rst0) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            cnt_q         <= '0;
            lat_a_q       <= '0;
            lat_b_q       <= '0;
            seen_a_q      <= 1'b0;
            seen_b_q      <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            err_early_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            cnt_q         <= cnt_d;
            lat_a_q       <= lat_a_d;
            lat_b_q       <= lat_b_d;
            seen_a_q      <= seen_a_d;
            seen_b_q      <= seen_b_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_timeout_q <= err_timeout_d;
            err_early_q   <= err_early_d;
        end
    end

    assign start1      = start_q;
    assign start2      = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign lat_a       = lat_a_q;
    assign lat_b       = lat_b_q;
    assign err_timeout = err_timeout_q;
    assign err_early   = err_early_q;

endmodule

// File: tb/tb_hop_chain_sequencer.sv
// Bench for hop_chain_sequencer: flop-chain models on both sides, a vector
// table, hand-written corner sequences and randomized runs.
module tb_hop_chain_sequencer;
    import hop_seq_pkg::*;

    localparam int NR = 16;
    localparam int TO = 63;
    localparam int CW = 72;

    typedef struct {
        int          la;
        int          lb;
        bit          ta;
        bit          tb;
        bit          early;
        bit          noise;
        hop_result_t exp;
    } vec_t;

    logic          clock0 = 1'b0;
    logic          rst0   = 1'b1;
    logic          go     = 1'b0;
    logic          chain_a_out;
    logic          chain_b_out;
    logic [NR-1:0] stage_rst;
    logic          start1, start2, busy, done, pass, err_timeout, err_early;
    logic [5:0]    lat_a, lat_b;

    int checks = 0;
    int errors = 0;

    int            len_a   = 9;
    int            len_b   = 9;
    bit            tie_a   = 1'b0;
    bit            tie_b   = 1'b0;
    bit            force_a = 1'b0;
    logic [CW-1:0] sh_a    = '0;
    logic [CW-1:0] sh_b    = '0;

    vec_t vecs[8];

    hop_chain_sequencer dut (
        .clock0      (clock0),
        .rst0        (rst0),
        .go          (go),
        .chain_a_out (chain_a_out),
        .chain_b_out (chain_b_out),
        .stage_rst   (stage_rst),
        .start1      (start1),
        .start2      (start2),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .lat_a       (lat_a),
        .lat_b       (lat_b),
        .err_timeout (err_timeout),
        .err_early   (err_early)
    );

    always #5 clock0 = ~clock0;

    // Chain models: each stage flop is cleared while its stage reset is high.
    always @(posedge clock0) begin
        sh_a <= {sh_a[CW-2:0], start1} & ~{{(CW-NR){1'b0}}, stage_rst};
        sh_b <= {sh_b[CW-2:0], start2} & ~{{(CW-NR){1'b0}}, stage_rst};
    end

    assign chain_a_out = force_a ? 1'b1 : (tie_a ? 1'b0 : sh_a[len_a-1]);
    assign chain_b_out = tie_b ? 1'b0 : sh_b[len_b-1];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic hop_result_t mk_res(bit p, int la, int lb, bit t, bit e);
        hop_result_t r;
        r.pass        = p;
        r.lat_a       = 6'(la);
        r.lat_b       = 6'(lb);
        r.err_timeout = t;
        r.err_early   = e;
        return r;
    endfunction

    function automatic hop_result_t act_res();
        return mk_res(pass, int'(lat_a), int'(lat_b), err_timeout, err_early);
    endfunction

    // Reference: a chain is seen iff it responds by counter value TO.
    function automatic int ref_wait(int la, int lb, bit ta, bit tb);
        bit sa = !ta && (la <= TO);
        bit sb = !tb && (lb <= TO);
        if (sa && sb) return (la > lb) ? la : lb;
        return TO;
    endfunction

    function automatic hop_result_t ref_result(int la, int lb, bit ta, bit tb, bit early);
        bit sa = !ta && (la <= TO);
        bit sb = !tb && (lb <= TO);
        bit p  = sa && sb && !early && (la == 9) && (lb == 9);
        return mk_res(p, sa ? la : 0, sb ? lb : 0, !(sa && sb), early);
    endfunction

    // Cycle c counts from the edge that accepts go (c=1 is the first ASSERT cycle).
    task automatic check_tl(input string nm, input int c, input int w);
        logic [NR-1:0] ones = '1;
        logic [NR-1:0] sr;
        logic [19:0]   exp;
        logic [19:0]   act;
        if (c <= 4 || c > 24 + w) sr = ones;
        else if (c <= 20)         sr = ones << (c - 4);
        else                      sr = '0;
        exp = {sr, c == 23, c == 23, c <= 24 + w, c == 24 + w};
        act = {stage_rst, start1, start2, busy, done};
        chk($sformatf("%s timeline c%0d", nm, c), 64'(act), 64'(exp));
    endtask

    task automatic run_case(input string nm, input int la, input int lb, input bit ta,
                            input bit tb, input bit early, input bit noise,
                            input hop_result_t exp);
        int w;
        w     = ref_wait(la, lb, ta, tb);
        len_a = la;
        len_b = lb;
        tie_a = ta;
        tie_b = tb;
        go    = 1'b1;
        for (int c = 1; c <= 25 + w; c++) begin
            tick();
            go      = noise && (c == 25 || c == 24 + w);
            force_a = early && (c == 21 || c == 22);
            check_tl(nm, c, w);
            if (c == 24 + w || c == 25 + w)
                chk($sformatf("%s result c%0d", nm, c), 64'(act_res()), 64'(exp));
        end
        go      = 1'b0;
        force_a = 1'b0;
    endtask

    initial begin
        int n;
        int la, lb;
        bit ta, tb, ea, nz;

        vecs[0] = '{la: 9,  lb: 9,  ta: 0, tb: 0, early: 0, noise: 0, exp: mk_res(1, 9, 9, 0, 0)};
        vecs[1] = '{la: 9,  lb: 10, ta: 0, tb: 0, early: 0, noise: 0, exp: mk_res(0, 9, 10, 0, 0)};
        vecs[2] = '{la: 9,  lb: 9,  ta: 0, tb: 1, early: 0, noise: 0, exp: mk_res(0, 9, 0, 1, 0)};
        vecs[3] = '{la: 9,  lb: 9,  ta: 0, tb: 0, early: 1, noise: 0, exp: mk_res(0, 9, 9, 0, 1)};
        vecs[4] = '{la: 63, lb: 9,  ta: 0, tb: 0, early: 0, noise: 0, exp: mk_res(0, 63, 9, 0, 0)};
        vecs[5] = '{la: 64, lb: 9,  ta: 0, tb: 0, early: 0, noise: 0, exp: mk_res(0, 0, 9, 1, 0)};
        vecs[6] = '{la: 9,  lb: 9,  ta: 1, tb: 1, early: 0, noise: 0, exp: mk_res(0, 0, 0, 1, 0)};
        vecs[7] = '{la: 9,  lb: 9,  ta: 0, tb: 0, early: 0, noise: 1, exp: mk_res(1, 9, 9, 0, 0)};

        rst0 = 1'b1;
        tick();
        tick();
        chk("reset outputs", 64'({stage_rst, start1, start2, busy, done}), 64'({16'hFFFF, 4'b0000}));
        chk("reset result", 64'(act_res()), 64'(mk_res(0, 0, 0, 0, 0)));
        rst0 = 1'b0;
        tick();
        chk("idle after reset", 64'({stage_rst, start1, start2, busy, done}), 64'({16'hFFFF, 4'b0000}));

        for (int i = 0; i < 8; i++)
            run_case($sformatf("vec%0d", i), vecs[i].la, vecs[i].lb, vecs[i].ta,
                     vecs[i].tb, vecs[i].early, vecs[i].noise, vecs[i].exp);

        // go held high: two back-to-back runs with one IDLE cycle between.
        len_a = 9; len_b = 9; tie_a = 0; tie_b = 0;
        go = 1'b1;
        for (int c = 1; c <= 68; c++) begin
            tick();
            if (c == 68) go = 1'b0;
            check_tl("held", (c <= 34) ? c : c - 34, 9);
            if (c == 33 || c == 67)
                chk($sformatf("held result c%0d", c), 64'(act_res()), 64'(mk_res(1, 9, 9, 0, 0)));
        end

        // Reset in RELEASE cycle k=7 aborts with no launch.
        go = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            go = 1'b0;
            check_tl("abort", c, 9);
        end
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk("abort idle", 64'({stage_rst, start1, start2, busy, done}), 64'({16'hFFFF, 4'b0000}));
        chk("abort result", 64'(act_res()), 64'(mk_res(0, 0, 0, 0, 0)));
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (start1 || start2 || busy) n++;
        end
        chk("abort quiet", 64'(n), 64'(0));
        run_case("after abort", 9, 9, 0, 0, 0, 0, mk_res(1, 9, 9, 0, 0));

        for (int i = 0; i < 12; i++) begin
            la = ($urandom_range(0, 2) == 0) ? 9 : int'($urandom_range(1, 20));
            lb = ($urandom_range(0, 2) == 0) ? 9 : int'($urandom_range(1, 20));
            ta = ($urandom_range(0, 7) == 0);
            tb = ($urandom_range(0, 7) == 0);
            ea = ($urandom_range(0, 4) == 0);
            nz = ($urandom_range(0, 1) == 1);
            run_case($sformatf("rand%0d", i), la, lb, ta, tb, ea, nz,
                     ref_result(la, lb, ta, tb, ea));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
